// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared constants and types for the instruction prefetch stage.
//   INST_NOP          instruction shown on inst before anything has been popped
//   PC_STEP           byte distance between sequential fetch addresses
//   RESET_PC_DEFAULT  default first fetch address after reset
//   fetch_entry_t     {inst, pc} pair at the default 32/64-bit widths
package fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h47FF_041F;
  localparam int unsigned PC_STEP          = 4;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small synchronous FIFO holding {inst, pc} entries for the prefetch stage.
//   Ports:
//     clk, rst_n   clock / synchronous active-low reset
//     push/wr_data write an entry (simultaneous push+pop allowed, also when full)
//     pop          remove the head entry
//     flush        discard all entries; wins over push and pop
//     rd_data      head entry (undefined when empty)
//     count        occupied entries, 0..DEPTH
//     full/empty   status flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 96,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // When full, a push is only legal together with a pop; the written slot is
  // the one being vacated, and the head is read from mem_q before the edge.
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2: wraps naturally
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count/pointers decide what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Slot reservation upstream must make an unmatched push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Prefetch stage between Icache and Ebox. Generates sequential fetch PCs,
//   keeps at most one Icache request outstanding and buffers returned
//   instructions with their PCs for Ebox. Redirects flush everything.
//   Ports:
//     clk, rst_n                  clock / synchronous active-low reset
//     icache_req, icache_addr     fetch request and its address
//     icache_rvalid, icache_rdata Icache response
//     inst_valid, inst_ready      head-entry handshake with Ebox
//     inst, inst_pc               head instruction and its PC
//     redirect_valid, redirect_pc control-flow redirect from Ebox
//     fill_count                  occupied FIFO entries
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              icache_req,
  output logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_rvalid,
  input  logic [INST_W-1:0] icache_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  fill_count
);

  localparam int unsigned       ENTRY_W       = INST_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_INC        = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] pending_pc_q, pending_pc_d;
  logic [INST_W-1:0] last_inst_q, last_inst_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [ENTRY_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;
  logic [INST_W-1:0]  head_inst;
  logic [ADDR_W-1:0]  head_pc;

  logic slot_free, issue, resp_push, pop;

  // An outstanding request already owns one slot, so with a request pending
  // the FIFO must have two free slots (one for it, one for the new request).
  assign slot_free = pending_q ? (fifo_count < CNT_W'(DEPTH - 1)) : !fifo_full;

  assign issue     = rst_n && !redirect_valid && (!pending_q || icache_rvalid) && slot_free;
  assign resp_push = pending_q && icache_rvalid && !redirect_valid;
  assign pop       = inst_valid && inst_ready;

  assign icache_req  = issue;
  assign icache_addr = fetch_pc_q;

  assign head_inst = fifo_rd_data[ENTRY_W-1 -: INST_W];
  assign head_pc   = fifo_rd_data[ADDR_W-1:0];

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign inst       = fifo_empty ? last_inst_q : head_inst;
  assign inst_pc    = fifo_empty ? last_pc_q   : head_pc;
  assign fill_count = fifo_count;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    last_inst_d  = last_inst_q;
    last_pc_d    = last_pc_q;
    if (redirect_valid) begin
      // Dropping pending also discards a response for the killed request
      // arriving next cycle: rvalid with nothing pending is ignored.
      pending_d  = 1'b0;
      fetch_pc_d = redirect_pc & PC_ALIGN_MASK;
    end else begin
      if (issue) begin
        pending_d    = 1'b1;
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + PC_INC;
      end else if (resp_push) begin
        pending_d = 1'b0;
      end
      if (pop) begin
        last_inst_d = head_inst;
        last_pc_d   = head_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      last_inst_q  <= INST_W'(INST_NOP);
      last_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      last_inst_q  <= last_inst_d;
      last_pc_q    <= last_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (resp_push),
    .wr_data ({icache_rdata, pending_pc_q}),
    .pop     (pop),
    .flush   (redirect_valid),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req;
  logic [63:0] icache_addr;
  logic        icache_rvalid;
  logic [31:0] icache_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [2:0]  fill_count;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(64), .INST_W(32), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fill_count(fill_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of delivered entries plus fetch bookkeeping
  fetch_entry_t q[$];
  fetch_entry_t m_last;
  bit           m_pend;
  logic [63:0]  m_pend_pc;
  logic [63:0]  m_fetch_pc;

  // Icache responder
  bit ic_busy = 0;
  int ic_cnt  = 0;
  int ic_dmin = 1;
  int ic_dmax = 1;
  bit force_rv = 0;

  // samples of the last cycle
  logic        s_req, s_valid;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;
  logic [2:0]  s_fill;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend     = 0;
    m_pend_pc  = 64'h0;
    m_fetch_pc = 64'h0;
    m_last     = '{inst: INST_NOP, pc: 64'h0};
  endtask

  task automatic cycle(input bit rst, input bit rdy, input bit redir, input logic [63:0] rpc);
    fetch_entry_t exp_head;
    bit           exp_valid, exp_req;
    rst_n          = rst;
    inst_ready     = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    icache_rvalid  = force_rv || (ic_busy && ic_cnt == 0);
    icache_rdata   = $urandom;
    #1;
    s_req = icache_req; s_addr = icache_addr; s_valid = inst_valid;
    s_pc = inst_pc; s_inst = inst; s_fill = fill_count;

    exp_valid = (q.size() != 0) && !redir;
    exp_head  = (q.size() != 0) ? q[0] : m_last;
    exp_req   = rst && !redir && (!m_pend || icache_rvalid) && (q.size() + int'(m_pend) < DEPTH);
    chk("icache_req", 64'(s_req), 64'(exp_req));
    chk("inst_valid", 64'(s_valid), 64'(exp_valid));
    chk("inst", 64'(s_inst), 64'(exp_head.inst));
    chk("inst_pc", s_pc, exp_head.pc);
    chk("fill_count", 64'(s_fill), 64'(q.size()));
    if (exp_req) chk("icache_addr", s_addr, m_fetch_pc);

    if (!rst) begin
      model_reset();
    end else if (redir) begin
      q.delete();
      m_pend     = 0;
      m_fetch_pc = rpc & ~64'h3;
    end else begin
      if (exp_valid && rdy) m_last = q.pop_front();
      if (m_pend && icache_rvalid) begin
        q.push_back('{inst: icache_rdata, pc: m_pend_pc});
        m_pend = 0;
      end
      if (exp_req) begin
        m_pend     = 1;
        m_pend_pc  = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end

    // responder: a redirect/reset cancels a request unless its answer is due next cycle
    if (icache_rvalid) ic_busy = 0;
    else if (ic_busy) begin
      if ((!rst || redir) && ic_cnt > 1) ic_busy = 0;
      else ic_cnt--;
    end
    if (s_req) begin
      ic_busy = 1;
      ic_cnt  = $urandom_range(ic_dmax, ic_dmin) - 1;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int nreq;
    rst_n = 0; inst_ready = 0; redirect_valid = 0; redirect_pc = 64'h0;
    icache_rvalid = 0; icache_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    chk("rst_icache_req", 64'(icache_req), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'h47FF041F);
    chk("rst_inst_pc", inst_pc, 64'h0);
    chk("rst_fill", 64'(fill_count), 64'd0);

    // 1: streaming, response one cycle after request, Ebox always ready
    ic_dmin = 1; ic_dmax = 1;
    for (int k = 0; k < 12; k++) begin
      cycle(1, 1, 0, 64'h0);
      if (k == 0) begin
        chk("t1_first_req", 64'(s_req), 64'd1);
        chk("t1_first_addr", s_addr, 64'h0);
      end
      if (k >= 2) begin
        chk("t1_valid", 64'(s_valid), 64'd1);
        chk("t1_pc", s_pc, 64'((k - 2) * 4));
      end
      chk("t1_fill_le1", 64'(s_fill <= 3'd1), 64'd1);
    end

    // 2: Ebox stalled, exactly DEPTH entries fetched, then drained in order
    cycle(0, 0, 0, 64'h0);
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 0, 64'h0);
      if (s_req) nreq++;
    end
    chk("t2_req_count", 64'(nreq), 64'd4);
    chk("t2_fill_full", 64'(s_fill), 64'd4);
    chk("t2_req_idle", 64'(s_req), 64'd0);
    for (int d = 0; d < 4; d++) begin
      cycle(1, 1, 0, 64'h0);
      chk("t2_drain_valid", 64'(s_valid), 64'd1);
      chk("t2_drain_pc", s_pc, 64'(d * 4));
      if (d == 1) begin
        chk("t2_resume_req", 64'(s_req), 64'd1);
        chk("t2_resume_addr", s_addr, 64'h10);
      end
    end

    // 3: redirect with 3 queued and 1 pending
    cycle(0, 0, 0, 64'h0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 64'h0);
    cycle(1, 0, 1, 64'h1003);
    chk("t3_fill_before", 64'(s_fill), 64'd3);
    cycle(1, 1, 0, 64'h0);
    chk("t3_valid_after", 64'(s_valid), 64'd0);
    chk("t3_fill_after", 64'(s_fill), 64'd0);
    chk("t3_req_after", 64'(s_req), 64'd1);
    chk("t3_addr_after", s_addr, 64'h1000);
    cycle(1, 1, 0, 64'h0);
    chk("t3_stale_dropped", 64'(s_valid), 64'd0);
    cycle(1, 1, 0, 64'h0);
    chk("t3_first_valid", 64'(s_valid), 64'd1);
    chk("t3_first_pc", s_pc, 64'h1000);

    // 4: Icache answers 3 cycles after request
    cycle(0, 0, 0, 64'h0);
    ic_dmin = 3; ic_dmax = 3;
    for (int k = 0; k < 14; k++) begin
      cycle(1, 1, 0, 64'h0);
      if (k == 1 || k == 2) chk("t4_no_second_req", 64'(s_req), 64'd0);
      if (k == 3) chk("t4_next_addr", s_addr, 64'h4);
      if (k == 4) chk("t4_pc0", s_pc, 64'h0);
    end

    // 5: fetch address wrap
    ic_dmin = 1; ic_dmax = 1;
    cycle(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    cycle(1, 1, 0, 64'h0);
    chk("t5_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 1, 0, 64'h0);
    chk("t5_addr_wrap", s_addr, 64'h0);
    cycle(1, 1, 0, 64'h0);
    chk("t5_pc_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1, 1, 0, 64'h0);
    chk("t5_pc_wrap", s_pc, 64'h0);

    // 6: reset mid-stream with a full FIFO
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 64'h0);
    chk("t6_full", 64'(s_fill), 64'd4);
    cycle(0, 0, 0, 64'h0);
    cycle(0, 0, 0, 64'h0);
    chk("t6_rst_valid", 64'(s_valid), 64'd0);
    chk("t6_rst_inst", 64'(s_inst), 64'h47FF041F);
    chk("t6_rst_pc", s_pc, 64'h0);
    chk("t6_rst_fill", 64'(s_fill), 64'd0);
    chk("t6_rst_req", 64'(s_req), 64'd0);
    force_rv = 1;
    cycle(1, 0, 0, 64'h0);
    force_rv = 0;
    chk("t6_restart_addr", s_addr, 64'h0);
    cycle(1, 0, 0, 64'h0);
    chk("t6_late_rvalid_ignored", 64'(s_fill), 64'd0);
    cycle(1, 0, 0, 64'h0);
    chk("t6_first_pc", s_pc, 64'h0);

    // random traffic: variable latency, stalls, redirects, occasional reset
    ic_dmin = 1; ic_dmax = 3;
    for (int k = 0; k < 600; k++) begin
      int r;
      logic [63:0] rpc;
      r = $urandom_range(99, 0);
      if ($urandom_range(3, 0) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
      else rpc = {$urandom, $urandom};
      if (r < 2)      cycle(0, 1'($urandom_range(1, 0)), 0, 64'h0);
      else if (r < 8) cycle(1, 1'($urandom_range(1, 0)), 1, rpc);
      else            cycle(1, $urandom_range(3, 0) != 0, 0, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
